// File: rtl/minimips_pkg.sv
// Shared definitions for the MiniMIPS core: fetch state encoding, reset
// defaults, opcode constants used by the decoders, and PC arithmetic.
package minimips_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Next-PC priority mux: jump target beats branch target beats PC+4 beats hold.
module pc_select
  import minimips_pkg::*;
(
  input  logic [31:0] pcf,
  input  logic        advance,
  input  logic        jump,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] seq_pc,
  output logic [31:0] next_pc
);

  logic [31:0] target;

  always_comb begin
    redirect = jump | branch;
    target   = jump ? jump_target : branch_target;
    seq_pc   = pc_plus4(pcf);
    if (redirect) begin
      next_pc = target;
    end else if (advance) begin
      next_pc = seq_pc;
    end else begin
      next_pc = pcf;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register for MiniMIPS. One outstanding
// request to a variable-latency instruction memory.
//
// Handshake: ImemReq is a one-cycle strobe; the address is captured by memory
// on that edge. ImemValid pulses exactly once per request, at least one cycle
// later, with ImemRdata valid in the same cycle. No backpressure to memory.
module fetch_stage
  import minimips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] JumpTargetD,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy,
  output logic [1:0]  StateDbg
);

  fetch_state_e state, state_next;
  logic         kill;
  logic [31:0]  hold_word;

  logic         redirect;
  logic [31:0]  seq_pc;
  logic [31:0]  next_pc;

  logic         issue_req;
  logic         resp_live;
  logic         deliver_mem;
  logic         deliver_buf;
  logic         capture;
  logic         kill_set;
  logic         kill_clr;

  pc_select u_pc_select (
    .pcf           (PCF),
    .advance       (deliver_mem | deliver_buf),
    .jump          (JumpD),
    .branch        (PCSrcD),
    .branch_target (PCBranchD),
    .jump_target   (JumpTargetD),
    .redirect      (redirect),
    .seq_pc        (seq_pc),
    .next_pc       (next_pc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_ISSUE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ISSUE: begin
        if (!redirect && !StallF) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ImemValid) begin
          if (kill || redirect || (!StallD && !FlushD)) state_next = ST_ISSUE;
          else                                         state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect || (!StallD && !FlushD)) state_next = ST_ISSUE;
      end
      default: state_next = ST_ISSUE;
    endcase
  end

  // A live response is one that was neither killed earlier nor overtaken by a
  // redirect arriving in the same cycle.
  always_comb begin
    issue_req   = (state == ST_ISSUE) && !StallF && !redirect;
    resp_live   = (state == ST_WAIT) && ImemValid && !kill && !redirect;
    deliver_mem = resp_live && !StallD && !FlushD;
    capture     = resp_live && (StallD || FlushD);
    deliver_buf = (state == ST_HOLD) && !redirect && !StallD && !FlushD;
    kill_set    = (state == ST_WAIT) && !ImemValid && redirect;
    kill_clr    = (state == ST_WAIT) && ImemValid;
    FetchBusy   = (state == ST_ISSUE) || ((state == ST_WAIT) && !(ImemValid && !kill));
    ImemReq     = issue_req && RST;
    ImemAddr    = PCF;
    StateDbg    = state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      kill <= 1'b0;
    end else if (kill_clr) begin
      kill <= 1'b0;
    end else if (kill_set) begin
      kill <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_word <= '0;
    end else if (capture) begin
      hold_word <= ImemRdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= next_pc;
    end
  end

  // Bubbles leave PCPlus4D untouched; only ValidD qualifies the contents.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (deliver_mem) begin
      InstrD   <= ImemRdata;
      PCPlus4D <= seq_pc;
      ValidD   <= 1'b1;
    end else if (deliver_buf) begin
      InstrD   <= hold_word;
      PCPlus4D <= seq_pc;
      ValidD   <= 1'b1;
    end else if (FlushD || !StallD) begin
      InstrD   <= NOP_INSTR;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run against a transaction-level fetch model.
module tb_fetch_stage;
  import minimips_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata = '0;
  logic        ImemValid = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        PCSrcD = 1'b0, JumpD = 1'b0;
  logic [31:0] PCBranchD = '0, JumpTargetD = '0;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD, FetchBusy;
  logic [1:0]  StateDbg;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemRdata(ImemRdata), .ImemValid(ImemValid), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .PCBranchD(PCBranchD), .JumpTargetD(JumpTargetD), .PCF(PCF),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchBusy(FetchBusy), .StateDbg(StateDbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  bit          m_out, m_stale, m_delivered;
  logic [31:0] held_q[$];
  logic [31:0] exp_q[$];

  // memory environment
  bit          mem_busy;
  int          mem_cnt;
  int          lat = 1;
  logic [31:0] mem_addr;
  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] salt = 32'h1357_9BDF;

  // per-cycle observations and expectations
  logic        obs_req, obs_busy, exp_req, exp_busy;
  logic [31:0] obs_addr, exp_addr;
  logic [1:0]  exp_state;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_out = 0; m_stale = 0; m_delivered = 0;
    held_q.delete();
    mem_busy = 0; mem_cnt = 0;
    ImemValid = 1'b0;
  endtask

  task automatic clear_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; JumpD = 0;
    PCBranchD = '0; JumpTargetD = '0;
  endtask

  // Advances one clock: drives the memory response, captures DUT outputs
  // before the edge, then steps the model after it.
  task automatic cycle();
    bit          redirect, idle;
    logic [31:0] target, w;
    if (mem_busy && mem_cnt == 1) begin
      ImemValid = 1'b1;
      ImemRdata = mem_word(mem_addr);
    end else begin
      ImemValid = 1'b0;
      ImemRdata = $urandom;
    end
    #1;
    obs_req  = ImemReq;
    obs_busy = FetchBusy;
    obs_addr = ImemAddr;
    redirect = JumpD || PCSrcD;
    target   = JumpD ? JumpTargetD : PCBranchD;
    idle     = !m_out && held_q.size() == 0;
    exp_req  = idle && !StallF && !redirect;
    exp_busy = idle || (m_out && !(ImemValid && !m_stale));
    exp_addr = m_pc;
    @(posedge CLK);
    #1;
    m_delivered = 0;
    w = '0;
    if (idle) begin
      if (exp_req) m_out = 1;
    end else if (m_out) begin
      if (!ImemValid) begin
        if (redirect) m_stale = 1;
      end else begin
        m_out = 0;
        if (m_stale || redirect) m_stale = 0;
        else if (!StallD && !FlushD) begin m_delivered = 1; w = ImemRdata; end
        else held_q.push_back(ImemRdata);
      end
    end else begin
      if (redirect) held_q.delete();
      else if (!StallD && !FlushD) begin m_delivered = 1; w = held_q.pop_front(); end
    end
    if (redirect) m_pc = target;
    if (m_delivered) begin
      m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      exp_q.push_back(w);
    end else if (FlushD || !StallD) begin
      m_instr = NOP; m_valid = 1'b0;
    end
    exp_state = (held_q.size() != 0) ? ST_HOLD : (m_out ? ST_WAIT : ST_ISSUE);
    if (ImemValid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (obs_req) begin
      mem_busy = 1; mem_cnt = lat; mem_addr = obs_addr;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge CLK); #1;
    checks++; if (PCF !== 32'h0)     begin failures++; $display("FAIL reset_pcf got=%h exp=%h", PCF, 32'h0); end
    checks++; if (InstrD !== NOP)    begin failures++; $display("FAIL reset_instr got=%h exp=%h", InstrD, NOP); end
    checks++; if (PCPlus4D !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", PCPlus4D, 32'h0); end
    checks++; if (ValidD !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", ValidD); end
    checks++; if (ImemReq !== 1'b0)  begin failures++; $display("FAIL reset_req got=%b exp=0", ImemReq); end
    checks++; if (StateDbg !== ST_ISSUE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", StateDbg, ST_ISSUE); end
    RST = 1'b1;
  endtask

  task automatic test_basic();
    mem_a[32'h0] = 32'h8C08_0004;
    mem_a[32'h4] = 32'h0109_5020;
    lat = 1;
    cycle();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin failures++; $display("FAIL basic_req0 got=%b/%h exp=1/%h", obs_req, obs_addr, 32'h0); end
    cycle();
    checks++; if (InstrD !== 32'h8C08_0004 || PCPlus4D !== 32'h4 || ValidD !== 1'b1) begin failures++; $display("FAIL basic_word0 got=%h/%h/%b exp=8c080004/00000004/1", InstrD, PCPlus4D, ValidD); end
    cycle();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin failures++; $display("FAIL basic_req1 got=%b/%h exp=1/%h", obs_req, obs_addr, 32'h4); end
    cycle();
    checks++; if (InstrD !== 32'h0109_5020 || PCPlus4D !== 32'h8 || ValidD !== 1'b1) begin failures++; $display("FAIL basic_word1 got=%h/%h/%b exp=01095020/00000008/1", InstrD, PCPlus4D, ValidD); end
  endtask

  task automatic test_latency3();
    bit busy_pat[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit req_pat[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit valid_pat[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (obs_busy !== busy_pat[i]) begin failures++; $display("FAIL lat3_busy[%0d] got=%b exp=%b", i, obs_busy, busy_pat[i]); end
      checks++; if (obs_req !== req_pat[i]) begin failures++; $display("FAIL lat3_req[%0d] got=%b exp=%b", i, obs_req, req_pat[i]); end
      checks++; if (ValidD !== valid_pat[i]) begin failures++; $display("FAIL lat3_valid[%0d] got=%b exp=%b", i, ValidD, valid_pat[i]); end
    end
    checks++; if (InstrD !== mem_word(32'h8) || PCPlus4D !== 32'hC) begin failures++; $display("FAIL lat3_word got=%h/%h exp=%h/%h", InstrD, PCPlus4D, mem_word(32'h8), 32'hC); end
  endtask

  task automatic test_jump_kill();
    lat = 3;
    cycle();
    JumpD = 1'b1; JumpTargetD = 32'h40;
    cycle();
    JumpD = 1'b0;
    checks++; if (PCF !== 32'h40 || StateDbg !== ST_WAIT) begin failures++; $display("FAIL kill_redirect got=%h/%0d exp=%h/%0d", PCF, StateDbg, 32'h40, ST_WAIT); end
    cycle();
    cycle();
    checks++; if (obs_busy !== 1'b1) begin failures++; $display("FAIL kill_busy got=%b exp=1", obs_busy); end
    checks++; if (ValidD !== 1'b0 || InstrD !== NOP || StateDbg !== ST_ISSUE) begin failures++; $display("FAIL kill_discard got=%b/%h/%0d exp=0/%h/%0d", ValidD, InstrD, StateDbg, NOP, ST_ISSUE); end
    cycle();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h40) begin failures++; $display("FAIL kill_refetch got=%b/%h exp=1/%h", obs_req, obs_addr, 32'h40); end
    repeat (3) cycle();
    checks++; if (InstrD !== mem_word(32'h40) || PCPlus4D !== 32'h44 || ValidD !== 1'b1) begin failures++; $display("FAIL kill_word got=%h/%h/%b exp=%h/%h/1", InstrD, PCPlus4D, ValidD, mem_word(32'h40), 32'h44); end
  endtask

  task automatic test_branch_same_cycle();
    lat = 1;
    cycle();
    PCSrcD = 1'b1; PCBranchD = 32'h100;
    cycle();
    PCSrcD = 1'b0;
    checks++; if (PCF !== 32'h100 || ValidD !== 1'b0 || StateDbg !== ST_ISSUE) begin failures++; $display("FAIL branch_drop got=%h/%b/%0d exp=%h/0/%0d", PCF, ValidD, StateDbg, 32'h100, ST_ISSUE); end
    checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL branch_busy got=%b exp=0", obs_busy); end
    cycle();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin failures++; $display("FAIL branch_refetch got=%b/%h exp=1/%h", obs_req, obs_addr, 32'h100); end
    cycle();
    checks++; if (InstrD !== mem_word(32'h100) || PCF !== 32'h104) begin failures++; $display("FAIL branch_word got=%h/%h exp=%h/%h", InstrD, PCF, mem_word(32'h100), 32'h104); end
  endtask

  task automatic test_hold();
    lat = 1;
    StallD = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (StateDbg !== ST_HOLD) begin failures++; $display("FAIL hold_state[%0d] got=%0d exp=%0d", i, StateDbg, ST_HOLD); end
      checks++; if (InstrD !== mem_word(32'h100) || PCPlus4D !== 32'h104 || ValidD !== 1'b1 || PCF !== 32'h104) begin
        failures++; $display("FAIL hold_ifid[%0d] got=%h/%h/%b/%h exp=%h/%h/1/%h", i, InstrD, PCPlus4D, ValidD, PCF, mem_word(32'h100), 32'h104, 32'h104);
      end
    end
    StallD = 1'b0;
    cycle();
    checks++; if (InstrD !== mem_word(32'h104) || PCPlus4D !== 32'h108 || ValidD !== 1'b1 || PCF !== 32'h108 || StateDbg !== ST_ISSUE) begin
      failures++; $display("FAIL hold_release got=%h/%h/%b/%h/%0d exp=%h/%h/1/%h/%0d", InstrD, PCPlus4D, ValidD, PCF, StateDbg, mem_word(32'h104), 32'h108, 32'h108, ST_ISSUE);
    end
  endtask

  task automatic test_wrap_and_reset();
    lat = 1;
    JumpD = 1'b1; JumpTargetD = 32'hFFFF_FFFC;
    cycle();
    JumpD = 1'b0;
    checks++; if (obs_req !== 1'b0 || PCF !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jump got=%b/%h exp=0/fffffffc", obs_req, PCF); end
    cycle();
    cycle();
    checks++; if (PCF !== 32'h0 || PCPlus4D !== 32'h0 || InstrD !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_pc got=%h/%h/%h exp=0/0/%h", PCF, PCPlus4D, InstrD, mem_word(32'hFFFF_FFFC)); end
    cycle();
    cycle();
    lat = 3;
    cycle();
    checks++; if (StateDbg !== ST_WAIT || PCF !== 32'h4) begin failures++; $display("FAIL wrap_wait got=%0d/%h exp=%0d/%h", StateDbg, PCF, ST_WAIT, 32'h4); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0 || InstrD !== NOP || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL async_reset_ifid got=%h/%h/%h/%b exp=0/%h/0/0", PCF, InstrD, PCPlus4D, ValidD, NOP); end
    checks++; if (ImemReq !== 1'b0 || StateDbg !== ST_ISSUE) begin failures++; $display("FAIL async_reset_ctl got=%b/%0d exp=0/%0d", ImemReq, StateDbg, ST_ISSUE); end
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [31:0] want;
    salt = $urandom;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      StallF = ($urandom_range(0, 3) == 0);
      StallD = ($urandom_range(0, 3) == 0);
      FlushD = ($urandom_range(0, 7) == 0);
      JumpD  = ($urandom_range(0, 11) == 0);
      PCSrcD = ($urandom_range(0, 9) == 0);
      t = $urandom; t[1:0] = 2'b00; JumpTargetD = t;
      t = $urandom; t[1:0] = 2'b00; PCBranchD = t;
      lat = $urandom_range(1, 4);
      cycle();
      checks++; if (obs_req !== exp_req) begin failures++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, obs_req, exp_req); end
      checks++; if (obs_busy !== exp_busy) begin failures++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, obs_busy, exp_busy); end
      checks++; if (obs_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, obs_addr, exp_addr); end
      checks++; if (PCF !== m_pc) begin failures++; $display("FAIL rnd_pcf[%0d] got=%h exp=%h", i, PCF, m_pc); end
      checks++; if (ValidD !== m_valid || InstrD !== m_instr) begin failures++; $display("FAIL rnd_instr[%0d] got=%b/%h exp=%b/%h", i, ValidD, InstrD, m_valid, m_instr); end
      checks++; if (PCPlus4D !== m_pc4) begin failures++; $display("FAIL rnd_pc4[%0d] got=%h exp=%h", i, PCPlus4D, m_pc4); end
      checks++; if (StateDbg !== exp_state) begin failures++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", i, StateDbg, exp_state); end
      if (m_delivered) begin
        want = exp_q.pop_front();
        checks++; if (InstrD !== want) begin failures++; $display("FAIL rnd_stream[%0d] got=%h exp=%h", i, InstrD, want); end
      end
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_latency3();
    test_jump_kill();
    test_branch_same_cycle();
    test_hold();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
